// File: rtl/rns_scale_sched.sv
// Round-robin sequencer around one shared RNS scaler (moduli 2^(N+1)-1, 2^N, 2^N-1).
// Each SCALE cycle divides the working operand by 2^N; the tagged result is offered on out_*.
//
// state | meaning
// IDLE  | arbitrate lanes from ptr, grant one and load its operand
// SCALE | one scaler pass per clock, cnt counts remaining passes
// DONE  | result held on out_* until out_ready
module rns_scale_sched #(
  parameter int N    = 5,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CW   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*(N+1)-1:0]  req_r1,
  input  logic [NREQ*N-1:0]      req_r2,
  input  logic [NREQ*N-1:0]      req_r3,
  input  logic [NREQ*CW-1:0]     req_passes,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N:0]             out_r1,
  output logic [N-1:0]           out_r2,
  output logic [N-1:0]           out_r3,
  output logic [IDW-1:0]         out_id,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, SCALE, DONE} state_t;

  localparam logic [N+1:0] M1 = (N+2)'((1 << (N+1)) - 1);
  localparam logic [N:0]   M3 = (N+1)'((1 << N) - 1);

  state_t          state, next_state;
  logic [IDW-1:0]  ptr, id, win;
  logic [IDW:0]    idx;
  logic [CW-1:0]   cnt, sel_p;
  logic [N:0]      work_r1, sel_r1, y1, kk;
  logic [N-1:0]    work_r2, work_r3, sel_r2, sel_r3, y2, y3;
  logic            found, take;

  // Both operands lie in [0, m1] (all-ones alias allowed); result is canonical.
  function automatic logic [N:0] sub_m1(input logic [N:0] a, input logic [N:0] b);
    logic [N+1:0] s;
    s = {1'b0, a} + M1 - {1'b0, b};
    if (s >= M1) s = s - M1;
    if (s >= M1) s = s - M1;
    return s[N:0];
  endfunction

  function automatic logic [N-1:0] sub_m3(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    s = {1'b0, a} + M3 - {1'b0, b};
    if (s >= M3) s = s - M3;
    if (s >= M3) s = s - M3;
    return s[N-1:0];
  endfunction

  // Doubling modulo 2^(N+1)-1 is a one-bit rotate; it is also the inverse of 2^N there.
  function automatic logic [N:0] dbl_m1(input logic [N:0] a);
    return {a[N-1:0], a[N]};
  endfunction

  // Y = (X - x2) / 2^N; y2 comes from a CRT rebuild of Y over (m1, m3), where 1/m3 = -2 mod m1.
  always_comb begin
    y1 = dbl_m1(sub_m1(work_r1, {1'b0, work_r2}));
    y3 = sub_m3(work_r3, work_r2);
    kk = dbl_m1(sub_m1({1'b0, y3}, y1));
    y2 = y3 - kk[N-1:0];
  end

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (req_valid[idx[IDW-1:0]]) begin
        win   = idx[IDW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_r1 = '0;
    sel_r2 = '0;
    sel_r3 = '0;
    sel_p  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_r1 = req_r1[i*(N+1) +: N+1];
        sel_r2 = req_r2[i*N +: N];
        sel_r3 = req_r3[i*N +: N];
        sel_p  = req_passes[i*CW +: CW];
      end
    end
  end

  always_comb begin
    next_state = state;
    take       = 1'b0;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (found) begin
          take           = 1'b1;
          req_ready[win] = 1'b1;
          next_state     = (sel_p != '0) ? SCALE : DONE;
        end
      end
      SCALE: if (cnt == CW'(1)) next_state = DONE;
      DONE:  if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (!rst_n) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      id      <= '0;
      work_r1 <= '0;
      work_r2 <= '0;
      work_r3 <= '0;
    end else begin
      state <= next_state;
      if (take) begin
        work_r1 <= sel_r1;
        work_r2 <= sel_r2;
        work_r3 <= sel_r3;
        cnt     <= sel_p;
        id      <= win;
      end
      if (state == SCALE) begin
        work_r1 <= y1;
        work_r2 <= y2;
        work_r3 <= y3;
        cnt     <= cnt - 1'b1;
      end
      if (state == DONE && out_ready)
        ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
    end
  end

  assign out_valid = rst_n && (state == DONE);
  assign busy      = rst_n && (state != IDLE);
  assign out_r1    = work_r1;
  assign out_r2    = work_r2;
  assign out_r3    = work_r3;
  assign out_id    = id;

endmodule

// File: tb/tb_rns_scale_sched.sv
// Bench for rns_scale_sched: integer reference (X >> N*P, round-robin arbitration) with a
// result scoreboard popped by an independent output monitor.
module tb_rns_scale_sched;
  localparam int N    = 5;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CW   = 3;
  localparam int M1   = (1 << (N + 1)) - 1;
  localparam int M2   = 1 << N;
  localparam int M3   = (1 << N) - 1;
  localparam int MR   = M1 * M2 * M3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*(N+1)-1:0] req_r1;
  logic [NREQ*N-1:0]     req_r2, req_r3;
  logic [NREQ*CW-1:0]    req_passes;
  logic                  out_valid, out_ready, busy;
  logic [N:0]            out_r1;
  logic [N-1:0]          out_r2, out_r3;
  logic [IDW-1:0]        out_id;

  rns_scale_sched #(.N(N), .NREQ(NREQ), .IDW(IDW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_r1(req_r1), .req_r2(req_r2), .req_r3(req_r3), .req_passes(req_passes),
    .out_valid(out_valid), .out_ready(out_ready), .out_r1(out_r1), .out_r2(out_r2),
    .out_r3(out_r3), .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int id; int r1; int r2; int r3;} exp_t;
  exp_t exp_q[$];
  int   grant_log[$];
  int   grant_cyc[$];

  int checks = 0;
  int failures = 0;
  int lane_x[NREQ];
  int lane_p[NREQ];
  bit in_flight = 0;
  int m_ptr = 0, cyc = 0, cur_p = 0, cur_id = 0, cycle_no = 0, rst_edges = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_lane(int i, int x, int p, bit al);
    int r1, r3;
    lane_x[i] = x;
    lane_p[i] = p;
    r1 = x % M1;
    r3 = x % M3;
    if (al && r1 == 0) r1 = M1;
    if (al && r3 == 0) r3 = M3;
    req_r1[i*(N+1) +: N+1] = (N+1)'(r1);
    req_r2[i*N +: N]       = N'(x % M2);
    req_r3[i*N +: N]       = N'(r3);
    req_passes[i*CW +: CW] = CW'(p);
    req_valid[i]           = 1'b1;
  endtask

  task automatic rand_lane(int i, int pmax);
    int x, sel;
    bit al;
    sel = $urandom_range(0, 5);
    al  = 1'b0;
    if (sel == 0) begin x = M1 * $urandom_range(0, MR / M1 - 1); al = 1'b1; end
    else if (sel == 1) begin x = M3 * $urandom_range(0, MR / M3 - 1); al = 1'b1; end
    else x = $urandom_range(0, MR - 1);
    set_lane(i, x, $urandom_range(0, pmax), al);
  endtask

  // One clock: check against the model, advance the model across the coming edge.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    int w, dut_w, res;
    exp_t e;
    #1;
    exp_rdy = '0;
    w = -1;
    dut_w = -1;
    for (int k = 0; k < NREQ; k++) if (req_ready[k]) dut_w = k;
    if (!rst_n) begin
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      if (rst_edges > 0) begin
        chk("rst_out_r1", int'(out_r1), 0);
        chk("rst_out_r2", int'(out_r2), 0);
        chk("rst_out_r3", int'(out_r3), 0);
        chk("rst_out_id", int'(out_id), 0);
      end
      rst_edges++;
      in_flight = 0;
      m_ptr = 0;
      exp_q.delete();
    end else begin
      rst_edges = 0;
      if (!in_flight)
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("grant", int'(req_ready), int'(exp_rdy));
      chk("busy", int'(busy), int'(in_flight));
      chk("out_valid_timing", int'(out_valid), int'(in_flight && cyc >= cur_p + 1));
      if (dut_w >= 0) begin
        grant_log.push_back(dut_w);
        grant_cyc.push_back(cycle_no);
      end
      if (w >= 0) begin
        res  = (N * lane_p[w] >= 31) ? 0 : (lane_x[w] >> (N * lane_p[w]));
        e.id = w;
        e.r1 = res % M1;
        e.r2 = res % M2;
        e.r3 = res % M3;
        exp_q.push_back(e);
        in_flight = 1;
        cyc = 1;
        cur_p = lane_p[w];
        cur_id = w;
      end else if (in_flight) begin
        if (cyc >= cur_p + 1 && out_ready) begin
          in_flight = 0;
          m_ptr = (cur_id + 1) % NREQ;
        end else cyc++;
      end
    end
    @(negedge clk);
    cycle_no++;
    if (w >= 0) req_valid[w] = 1'b0;
  endtask

  task automatic run_idle(int maxc);
    for (int c = 0; c < maxc; c++) begin
      if (!in_flight && req_valid == '0) break;
      step();
    end
    chk("drain_timeout", int'(in_flight || req_valid != '0), 0);
  endtask

  // Output monitor: pops the scoreboard on every accepted result, checks hold under backpressure.
  initial begin
    exp_t e;
    bit held;
    int h_r1, h_r2, h_r3, h_id;
    held = 0;
    h_r1 = 0; h_r2 = 0; h_r3 = 0; h_id = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) held = 0;
      else if (out_valid) begin
        if (held) begin
          chk("hold_r1", int'(out_r1), h_r1);
          chk("hold_r2", int'(out_r2), h_r2);
          chk("hold_r3", int'(out_r3), h_r3);
          chk("hold_id", int'(out_id), h_id);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) chk("scoreboard_nonempty", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("out_id", int'(out_id), e.id);
            chk("out_r1", int'(out_r1) % M1, e.r1);
            chk("out_r2", int'(out_r2), e.r2);
            chk("out_r3", int'(out_r3) % M3, e.r3);
          end
          held = 0;
        end else begin
          held = 1;
          h_r1 = out_r1; h_r2 = out_r2; h_r3 = out_r3; h_id = out_id;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_r1 = '0;
    req_r2 = '0;
    req_r3 = '0;
    req_passes = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin lane_x[i] = 0; lane_p[i] = 0; end
    @(negedge clk);

    // Reset with random request activity, then lowest requesting lane wins.
    for (int c = 0; c < 3; c++) begin
      req_valid = NREQ'($urandom);
      step();
    end
    req_valid = '0;
    rand_lane(1, 3);
    rand_lane(3, 3);
    rst_n = 1'b1;
    out_ready = 1'b1;
    grant_log.delete();
    step();
    chk("first_grant_lane", grant_log.size() > 0 ? grant_log[0] : -1, 1);
    run_idle(40);

    // Golden single- and two-pass operands.
    set_lane(2, 3200, 1, 0);
    run_idle(20);
    set_lane(0, 51200, 2, 0);
    run_idle(20);

    // Round-robin with all lanes continuously requesting.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_lane(i, $urandom_range(0, MR - 1), 1, 0);
    grant_log.delete();
    grant_cyc.delete();
    for (int c = 0; c < 16; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) if (!req_valid[i]) set_lane(i, $urandom_range(0, MR - 1), 1, 0);
    end
    chk("rr_grant_count", grant_log.size() >= 5, 1);
    if (grant_log.size() >= 5)
      for (int k = 0; k < 5; k++) begin
        chk("rr_order", grant_log[k], k % NREQ);
        if (k > 0) chk("rr_interval", grant_cyc[k] - grant_cyc[k-1], 3);
      end
    req_valid = '0;
    run_idle(20);

    // Backpressure: DONE held with competing requests.
    out_ready = 1'b0;
    set_lane(1, $urandom_range(0, MR - 1), 1, 0);
    step();
    set_lane(0, $urandom_range(0, MR - 1), 2, 0);
    set_lane(2, $urandom_range(0, MR - 1), 0, 1);
    set_lane(3, $urandom_range(0, MR - 1), 3, 0);
    for (int c = 0; c < 12; c++) step();
    out_ready = 1'b1;
    run_idle(40);

    // Reset mid-SCALE: ptr returns to 0, aborted result never appears.
    set_lane(1, $urandom_range(0, MR - 1), 0, 0);
    run_idle(10);
    set_lane(3, $urandom_range(0, MR - 1), 5, 0);
    for (int c = 0; c < 3; c++) step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    req_valid = '0;
    grant_log.delete();
    set_lane(1, $urandom_range(0, MR - 1), 0, 1);
    set_lane(3, $urandom_range(0, MR - 1), 0, 0);
    step();
    chk("post_reset_grant", grant_log.size() > 0 ? grant_log[0] : -1, 1);
    run_idle(20);

    // Random traffic, drops and backpressure.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) rand_lane(i, ($urandom_range(0, 7) == 0) ? 7 : 3);
        else if (req_valid[i] && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    out_ready = 1'b1;
    run_idle(40);
    step();
    step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
